// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared interrupt constants and pending-state encoding
package irq_pkg;

    localparam int N_IRQ           = 32;
    localparam int IRQ_SYNC_STAGES = 2;
    // Bit of mcause that marks an interrupt (vs. exception) cause.
    localparam int MCAUSE_INT_BIT  = 31;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_t;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-flop synchronizer for a vector of asynchronous lines
module irq_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// rtl/irq_request_latch.sv - per-line edge/level interrupt capture feeding the interrupt controller
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int N_IRQ       = irq_pkg::N_IRQ,
    parameter int SYNC_STAGES = IRQ_SYNC_STAGES
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [N_IRQ-1:0]        irq_i,
    input  logic [N_IRQ-1:0]        edge_mode_i,
    input  logic [N_IRQ-1:0]        int_fin_i,
    input  logic [N_IRQ-1:0]        ovf_clr_i,
    output logic [N_IRQ-1:0]        int_req_o,
    output logic [N_IRQ-1:0]        irq_ack_o,
    output logic [N_IRQ-1:0]        irq_ovf_o,
    output logic [$clog2(N_IRQ):0]  pend_cnt_o
);

    localparam int CNT_W = $clog2(N_IRQ) + 1;

    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] edge_q;
    logic [N_IRQ-1:0] req_d;
    logic [CNT_W-1:0] cnt_d;

    irq_sync #(
        .WIDTH  (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .d_i     (irq_i),
        .q_o     (s)
    );

    // prev tracks s in every mode, so returning to edge mode on a high line sees no edge.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            prev_q <= s;
            edge_q <= edge_mode_i;
        end
    end

    for (genvar n = 0; n < N_IRQ; n++) begin : g_line
        irq_state_t state_q;
        irq_state_t state_d;
        logic       rise;
        logic       mode_chg;
        logic       ovf_q;
        logic       ovf_d;
        logic       req_q;
        logic       ack_q;

        assign rise     = s[n] & ~prev_q[n];
        assign mode_chg = edge_q[n] ^ edge_mode_i[n];

        always_comb begin
            state_d = state_q;
            ovf_d   = ovf_q;
            if (mode_chg || !edge_q[n]) begin
                state_d = IRQ_IDLE;
            end else begin
                case (state_q)
                    IRQ_IDLE: if (rise) state_d = IRQ_PEND;
                    IRQ_PEND: if (int_fin_i[n] && !rise) state_d = IRQ_IDLE;
                endcase
            end
            // A lost edge wins over a same-cycle clear.
            if (mode_chg) begin
                ovf_d = 1'b0;
            end else if (edge_q[n] && state_q == IRQ_PEND && rise && !int_fin_i[n]) begin
                ovf_d = 1'b1;
            end else if (ovf_clr_i[n]) begin
                ovf_d = 1'b0;
            end
        end

        assign req_d[n] = edge_mode_i[n] ? (state_d == IRQ_PEND) : s[n];

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                state_q <= IRQ_IDLE;
                ovf_q   <= 1'b0;
                req_q   <= 1'b0;
                ack_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ovf_q   <= ovf_d;
                req_q   <= req_d[n];
                ack_q   <= int_fin_i[n];
            end
        end

        assign int_req_o[n] = req_q;
        assign irq_ack_o[n] = ack_q;
        assign irq_ovf_o[n] = ovf_q;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            cnt_d = cnt_d + CNT_W'(req_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pend_cnt_o <= '0;
        end else begin
            pend_cnt_o <= cnt_d;
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// tb/tb_irq_request_latch.sv - directed self-checking bench for irq_request_latch
module tb_irq_request_latch;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [31:0] irq_i;
    logic [31:0] edge_mode_i;
    logic [31:0] int_fin_i;
    logic [31:0] ovf_clr_i;
    logic [31:0] int_req_o;
    logic [31:0] irq_ack_o;
    logic [31:0] irq_ovf_o;
    logic [5:0]  pend_cnt_o;

    int checks   = 0;
    int failures = 0;

    irq_request_latch dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .irq_i       (irq_i),
        .edge_mode_i (edge_mode_i),
        .int_fin_i   (int_fin_i),
        .ovf_clr_i   (ovf_clr_i),
        .int_req_o   (int_req_o),
        .irq_ack_o   (irq_ack_o),
        .irq_ovf_o   (irq_ovf_o),
        .pend_cnt_o  (pend_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        arstn_i     = 1'b0;
        irq_i       = 32'hFFFF_FFFF;
        edge_mode_i = 32'hFFFF_FFFF;
        int_fin_i   = '0;
        ovf_clr_i   = '0;
        repeat (3) tick();
        chk("rst_req", int_req_o, 0);
        chk("rst_ack", irq_ack_o, 0);
        chk("rst_ovf", irq_ovf_o, 0);
        chk("rst_cnt", pend_cnt_o, 0);

        // Lines held high through release are seen as edges.
        arstn_i = 1'b1;
        tick();
        chk("rel_p1", int_req_o, 0);
        tick();
        chk("rel_p2", int_req_o, 0);
        tick();
        chk("rel_p3_req", int_req_o, 32'hFFFF_FFFF);
        chk("rel_p3_cnt", pend_cnt_o, 32);

        irq_i = '0;
        repeat (3) tick();
        int_fin_i = 32'hFFFF_FFFF;
        tick();
        int_fin_i = '0;
        chk("fin_all_req", int_req_o, 0);
        chk("fin_all_ack", irq_ack_o, 32'hFFFF_FFFF);
        chk("fin_all_cnt", pend_cnt_o, 0);
        tick();
        chk("fin_all_ack_end", irq_ack_o, 0);

        // Line 5 edge latency and acknowledge
        irq_i[5] = 1'b1;
        tick();
        chk("l5_p1", int_req_o, 0);
        tick();
        irq_i[5] = 1'b0;
        chk("l5_p2", int_req_o, 0);
        tick();
        chk("l5_p3_req", int_req_o, 32'h20);
        chk("l5_p3_cnt", pend_cnt_o, 1);
        repeat (2) tick();
        int_fin_i = 32'h20;
        tick();
        int_fin_i = '0;
        chk("l5_fin_req", int_req_o, 0);
        chk("l5_fin_ack", irq_ack_o, 32'h20);
        chk("l5_fin_cnt", pend_cnt_o, 0);
        tick();
        chk("l5_ack_pulse", irq_ack_o, 0);

        // Line 3 overflow
        irq_i[3] = 1'b1;
        repeat (2) tick();
        irq_i[3] = 1'b0;
        tick();
        chk("l3_pend", int_req_o, 32'h8);
        repeat (3) tick();
        irq_i[3] = 1'b1;
        repeat (2) tick();
        irq_i[3] = 1'b0;
        tick();
        chk("l3_ovf_set", irq_ovf_o, 32'h8);
        chk("l3_ovf_req", int_req_o, 32'h8);
        repeat (3) tick();
        ovf_clr_i = 32'h8;
        tick();
        ovf_clr_i = '0;
        chk("l3_ovf_clr", irq_ovf_o, 0);
        irq_i[3] = 1'b1;
        repeat (2) tick();
        irq_i[3] = 1'b0;
        ovf_clr_i = 32'h8;
        tick();
        ovf_clr_i = '0;
        chk("l3_set_beats_clr", irq_ovf_o, 32'h8);
        repeat (3) tick();
        int_fin_i = 32'h8;
        ovf_clr_i = 32'h8;
        tick();
        int_fin_i = '0;
        ovf_clr_i = '0;
        chk("l3_cleanup_req", int_req_o, 0);
        chk("l3_cleanup_ovf", irq_ovf_o, 0);

        // Line 7 fin in the same cycle as a new edge
        irq_i[7] = 1'b1;
        repeat (2) tick();
        irq_i[7] = 1'b0;
        tick();
        chk("l7_pend", int_req_o, 32'h80);
        repeat (3) tick();
        irq_i[7] = 1'b1;
        repeat (2) tick();
        irq_i[7] = 1'b0;
        int_fin_i = 32'h80;
        tick();
        int_fin_i = '0;
        chk("l7_keep_req", int_req_o, 32'h80);
        chk("l7_no_ovf", irq_ovf_o, 0);
        chk("l7_ack", irq_ack_o, 32'h80);
        tick();
        chk("l7_ack_pulse", irq_ack_o, 0);
        repeat (2) tick();
        int_fin_i = 32'h80;
        tick();
        int_fin_i = '0;
        chk("l7_cleared", int_req_o, 0);

        // Line 0 level mode
        edge_mode_i = 32'hFFFF_FFFE;
        repeat (2) tick();
        irq_i[0] = 1'b1;
        repeat (3) tick();
        chk("l0_level_req", int_req_o, 32'h1);
        chk("l0_level_cnt", pend_cnt_o, 1);
        tick();
        int_fin_i = 32'h1;
        tick();
        int_fin_i = '0;
        chk("l0_fin_req", int_req_o, 32'h1);
        chk("l0_fin_ack", irq_ack_o, 32'h1);
        tick();
        chk("l0_ack_pulse", irq_ack_o, 0);
        chk("l0_held", int_req_o, 32'h1);
        repeat (4) tick();
        irq_i[0] = 1'b0;
        repeat (2) tick();
        chk("l0_fall_p2", int_req_o, 32'h1);
        tick();
        chk("l0_fall_p3", int_req_o, 0);
        chk("l0_no_ovf", irq_ovf_o, 0);

        // Line 9 mode switching
        edge_mode_i = 32'hFFFF_FFFF;
        repeat (2) tick();
        irq_i[9] = 1'b1;
        repeat (2) tick();
        irq_i[9] = 1'b0;
        tick();
        chk("l9_pend", int_req_o, 32'h200);
        repeat (3) tick();
        irq_i[9] = 1'b1;
        repeat (2) tick();
        irq_i[9] = 1'b0;
        tick();
        chk("l9_ovf", irq_ovf_o, 32'h200);
        repeat (3) tick();
        edge_mode_i[9] = 1'b0;
        tick();
        chk("l9_sw_req", int_req_o, 0);
        chk("l9_sw_ovf", irq_ovf_o, 0);
        chk("l9_sw_cnt", pend_cnt_o, 0);
        irq_i[9] = 1'b1;
        repeat (3) tick();
        chk("l9_level_req", int_req_o, 32'h200);
        edge_mode_i[9] = 1'b1;
        tick();
        chk("l9_back_req", int_req_o, 0);
        repeat (4) tick();
        chk("l9_no_spurious", int_req_o, 0);
        chk("l9_no_spurious_cnt", pend_cnt_o, 0);

        // Stray fin and asynchronous reset mid-operation
        irq_i[12] = 1'b1;
        repeat (3) tick();
        chk("l12_pend", int_req_o, 32'h1000);
        int_fin_i = 32'h400;
        tick();
        int_fin_i = '0;
        chk("stray_ack", irq_ack_o, 32'h400);
        chk("stray_req", int_req_o, 32'h1000);
        #2;
        arstn_i = 1'b0;
        #1;
        chk("async_req", int_req_o, 0);
        chk("async_ack", irq_ack_o, 0);
        chk("async_cnt", pend_cnt_o, 0);
        chk("async_ovf", irq_ovf_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
